spi_slave_regs: RTL

//  - SPI slave (mode 0, MSB first) consuming 24-bit frames {cmd[7:0], addr[7:0], payload[7:0]} from spi_master_mock.
//  - Decodes write/read commands against a small register bank in the sysclk domain.
//  - Returns register data on miso during the payload phase, for read commands only.
//  - Drives o_brightness, the LED-brightness control downstream of the SPI link.

---
 rtl/spi_slave_regs_pkg.sv | 35 +++
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_regs.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regs_pkg.sv
// Shared constants, command codes and FSM encoding
// for the SPI register-bank slave.
package spi_slave_regs_pkg;

   localparam int CMD_BITS           = 8;
   localparam int ADDR_BITS          = 8;
   localparam int PAYLOAD_BITS       = 8;
   localparam int MASTER_FRAME_WIDTH = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;
   localparam int BRIGHTNESS_WIDTH   = 7;

   localparam logic CS_ASSERT   = 1'b0;
   localparam logic CS_DEASSERT = 1'b1;

   localparam int REG_COUNT = 4;
   localparam int IDX_W     = 2;

   localparam logic [7:0] CMD_WRITE = 8'h80;
   localparam logic [7:0] CMD_READ  = 8'h40;

   localparam logic [4:0] CNT_MAX     = 5'd31;
   localparam logic [4:0] CNT_TX_LOAD = 5'd16;
   localparam logic [4:0] CNT_FRAME   = 5'd24;

   typedef enum logic [1:0] {
      ST_WAIT_IDLE = 2'd0,
      ST_IDLE      = 2'd1,
      ST_SHIFT     = 2'd2,
      ST_EVAL      = 2'd3
   } state_e;

   function automatic logic addr_in_range(input logic [7:0] a);
      return a < 8'(REG_COUNT);
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for edge detect.
// Level and edges are all taken from the second stage.
module spi_sync_edge #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic s1_q, s2_q, s3_q;

   // Shift the async input through the sync chain
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= RST_VAL;
         s2_q <= RST_VAL;
         s3_q <= RST_VAL;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign lvl_o  = s2_q;
   assign rise_o = s2_q & ~s3_q;
   assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave_regs.sv
// Mode-0 SPI slave decoding 24-bit write/read frames
// against a small register bank in the sysclk domain.
module spi_slave_regs
   import spi_slave_regs_pkg::*;
(
   input  logic                        sysclk,
   input  logic                        rst,
   input  logic                        cs,
   input  logic                        sclk,
   input  logic                        mosi,
   output logic                        miso,
   output logic                        o_frame_valid,
   output logic [7:0]                  o_cmd,
   output logic [7:0]                  o_addr,
   output logic [7:0]                  o_payload,
   output logic                        o_frame_err,
   output logic [BRIGHTNESS_WIDTH-1:0] o_brightness
);

   logic cs_lvl, cs_rise, cs_fall, cs_end;
   logic sclk_lvl, sclk_rise, sclk_fall;
   logic mosi_s1_q, mosi_s2_q;

   // cs resets to asserted so a frame already in flight
   // at reset release is held off in WAIT_IDLE
   spi_sync_edge #(.RST_VAL(CS_ASSERT)) u_cs_sync (
      .clk_i  (sysclk),
      .rst_i  (rst),
      .d_i    (cs),
      .lvl_o  (cs_lvl),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
      .clk_i  (sysclk),
      .rst_i  (rst),
      .d_i    (sclk),
      .lvl_o  (sclk_lvl),
      .rise_o (sclk_rise),
      .fall_o (sclk_fall)
   );

   assign cs_end = (CS_DEASSERT == 1'b1) ? cs_rise : cs_fall;

   // Plain 2-flop synchroniser for mosi, aligned with sclk
   always_ff @(posedge sysclk) begin
      if (rst) begin
         mosi_s1_q <= 1'b0;
         mosi_s2_q <= 1'b0;
      end else begin
         mosi_s1_q <= mosi;
         mosi_s2_q <= mosi_s1_q;
      end
   end

   state_e state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;
   logic [7:0]  tx_q, tx_d;
   logic        miso_q, miso_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  pay_q, pay_d;
   logic        vld_q, vld_d;
   logic        err_q, err_d;
   logic [7:0]  reg_q [REG_COUNT];
   logic [7:0]  reg_d [REG_COUNT];
   logic [BRIGHTNESS_WIDTH-1:0] bri_q, bri_d;

   logic [7:0] hdr_cmd, hdr_addr;
   logic [7:0] f_cmd, f_addr, f_pay;

   assign hdr_cmd  = sh_q[15:8];
   assign hdr_addr = sh_q[7:0];
   assign f_cmd    = sh_q[23:16];
   assign f_addr   = sh_q[15:8];
   assign f_pay    = sh_q[7:0];

   // Next-state, shift datapath, miso and frame decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      pay_d   = pay_q;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      reg_d   = reg_q;
      bri_d   = reg_q[0][7:1];

      unique case (state_q)
         ST_WAIT_IDLE: begin
            if (cs_lvl == CS_DEASSERT) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            cnt_d  = '0;
            sh_d   = '0;
            tx_d   = '0;
            miso_d = 1'b0;
            if (cs_lvl == CS_ASSERT && !sclk_lvl)
               state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sclk_rise) begin
               sh_d = {sh_q[22:0], mosi_s2_q};
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 5'd1;
            end
            if (sclk_fall) begin
               if (cnt_q < CNT_TX_LOAD) begin
                  miso_d = 1'b0;
               end else if (cnt_q == CNT_TX_LOAD) begin
                  if (hdr_cmd == CMD_READ && addr_in_range(hdr_addr))
                     tx_d = reg_q[hdr_addr[IDX_W-1:0]];
                  else
                     tx_d = 8'h00;
                  miso_d = tx_d[7];
               end else if (cnt_q < CNT_FRAME) begin
                  tx_d   = {tx_q[6:0], 1'b0};
                  miso_d = tx_q[6];
               end else begin
                  miso_d = 1'b0;
               end
            end
            if (cs_end) state_d = ST_EVAL;
         end
         ST_EVAL: begin
            if (cnt_q == CNT_FRAME) begin
               cmd_d  = f_cmd;
               addr_d = f_addr;
               pay_d  = f_pay;
               vld_d  = 1'b1;
               if (f_cmd == CMD_WRITE && addr_in_range(f_addr))
                  reg_d[f_addr[IDX_W-1:0]] = f_pay;
            end else begin
               err_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_WAIT_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q <= ST_WAIT_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         tx_q    <= '0;
         miso_q  <= 1'b0;
         cmd_q   <= '0;
         addr_q  <= '0;
         pay_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         reg_q   <= '{default: '0};
         bri_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
         miso_q  <= miso_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         pay_q   <= pay_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
         reg_q   <= reg_d;
         bri_q   <= bri_d;
      end
   end

   assign miso          = miso_q;
   assign o_frame_valid = vld_q;
   assign o_frame_err   = err_q;
   assign o_cmd         = cmd_q;
   assign o_addr        = addr_q;
   assign o_payload     = pay_q;
   assign o_brightness  = bri_q;

endmodule
